// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one bit per clk, start / LSB-first data / optional parity / stop.
// Optional macro UART_TX_TWO_STOP_EN selects two stop bits instead of one.
//
// state  | meaning
// IDLE   | line high, ready for a request
// START  | start bit (0) on the line
// DATA   | data bits on the line, LSB first
// PARITY | parity bit on the line
// STOP   | stop bit(s) on the line; last stop cycle can accept the next frame
module uart_tx_serializer #(
  parameter int frame_data = 8,
  parameter int bit_cnt_w  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [frame_data-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [bit_cnt_w-1:0] LAST_BIT = bit_cnt_w'(frame_data - 1);

  state_t                state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [frame_data-1:0] shreg_q, shreg_d;
  logic [bit_cnt_w-1:0]  cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_acc_q, par_acc_d;
  logic                  stop_last;
  logic                  accept;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_cnt_q, stop_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stop_cnt_q <= 1'b0;
    else      stop_cnt_q <= stop_cnt_d;
  end

  assign stop_last = stop_cnt_q;
`else
  assign stop_last = 1'b1;
`endif

  assign accept = data_valid && ((state_q == IDLE) || ((state_q == STOP) && stop_last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_acc_q <= par_acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_acc_d = par_acc_q;
`ifdef UART_TX_TWO_STOP_EN
    stop_cnt_d = stop_cnt_q;
`endif

    if (accept) begin
      state_d   = START;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      shreg_d   = p_data;
      cnt_d     = '0;
      par_en_d  = par_en;
      par_typ_d = par_typ;
      par_acc_d = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_d = 1'b0;
`endif
    end else begin
      case (state_q)
        START: begin
          state_d   = DATA;
          tx_d      = shreg_q[0];
          par_acc_d = par_acc_q ^ shreg_q[0];
          shreg_d   = shreg_q >> 1;
          cnt_d     = '0;
        end
        DATA: begin
          if (cnt_q == LAST_BIT) begin
            // par_acc_q already folds in every data bit that went out
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_acc_q ^ par_typ_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d      = shreg_q[0];
            par_acc_d = par_acc_q ^ shreg_q[0];
            shreg_d   = shreg_q >> 1;
            cnt_d     = cnt_q + bit_cnt_w'(1);
          end
        end
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        STOP: begin
          tx_d = 1'b1;
          if (stop_last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`ifdef UART_TX_TWO_STOP_EN
          else begin
            stop_cnt_d = 1'b1;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: directed and random requests against a line-level frame queue model.
module tb_uart_tx_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // expected line value for each upcoming cycle; empty means idle
  logic q[$];

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  uart_tx_serializer #(.frame_data(8), .bit_cnt_w(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) q.push_back(((ones % 2) == 1) ^ pt);
    for (int i = 0; i < STOP_BITS; i++) q.push_back(1'b1);
  endfunction

  task automatic check_line(input string tag);
    logic exp_tx;
    logic exp_busy;
    exp_tx   = (q.size() != 0) ? q[0] : 1'b1;
    exp_busy = (q.size() != 0);
    total_cnt++;
    assert (tx_out === exp_tx) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s tx_out observed=%b expected=%b t=%0t", tag, tx_out, exp_tx, $time);
    end
    total_cnt++;
    assert (busy === exp_busy) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s busy observed=%b expected=%b t=%0t", tag, busy, exp_busy, $time);
    end
  endtask

  // called at a falling edge: check this cycle, then drive inputs for the next rising edge
  task automatic step(input string tag, input logic dv, input logic [7:0] d,
                      input logic pe, input logic pt);
    check_line(tag);
    if (q.size() != 0) void'(q.pop_front());
    data_valid = dv;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    if (dv && rst && q.size() == 0) push_frame(d, pe, pt);
    @(negedge clk);
  endtask

  int flen;

  initial begin
    rst        = 1'b0;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    flen       = 1 + 8 + STOP_BITS;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    step("a5_nopar", 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < flen + 2; i++) step("a5_nopar", 1'b0, 8'h00, 1'b0, 1'b0);

    step("par_even", 1'b1, 8'h07, 1'b1, 1'b0);
    for (int i = 0; i < flen + 3; i++) step("par_even", 1'b0, 8'hFF, 1'b0, 1'b1);
    step("par_odd", 1'b1, 8'h07, 1'b1, 1'b1);
    for (int i = 0; i < flen + 3; i++) step("par_odd", 1'b0, 8'h00, 1'b1, 1'b0);

    step("b2b", 1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < flen; i++) step("b2b", 1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < flen + 2; i++) step("b2b", 1'b0, 8'h00, 1'b0, 1'b0);

    step("ignore", 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("ignore", 1'b0, 8'h00, 1'b0, 1'b0);
    step("ignore", 1'b1, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < flen + 4; i++) step("ignore", 1'b0, 8'h00, 1'b0, 1'b0);

    step("midrst", 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("midrst", 1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b0;
    q.delete();
    #1 check_line("midrst_async");
    @(negedge clk);
    for (int i = 0; i < 2; i++) step("midrst_hold", 1'b1, 8'h3C, 1'b0, 1'b0);
    rst = 1'b1;
    step("after_rst", 1'b1, 8'h3C, 1'b1, 1'b0);
    for (int i = 0; i < flen + 3; i++) step("after_rst", 1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++)
      step("random", ($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < flen + 3; i++) step("drain", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
